// File: rtl/mips_hazard_ctrl.sv
// mips_hazard_ctrl
// Interlock controller that sits beside the ID stage of mips_pipeline.
// - A per-register countdown scoreboard holds RAW-dependent instructions in ID
//   until the producer's result is readable from the register file.
// - A two-state FSM freezes fetch and flushes IF/ID while a control
//   instruction resolves, then tells the datapath to redirect the PC.
// Pipeline-control outputs are combinational because they steer the same
// clock edge. The stall counter is the only registered output.

module mips_hazard_ctrl #(
  parameter int WB_LAT = 3,   // producer issue -> result readable (RAW distance)
  parameter int BR_LAT = 3,   // control issue -> next-PC resolved
  parameter int CNT_W  = 16   // stall-cycle counter width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_we_i,
  input  logic [4:0]       id_wd_i,
  input  logic             id_ctrl_i,
  output logic             issue_o,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             redirect_o,
  output logic             br_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Scoreboard entry width. One bit is kept as a floor so that WB_LAT=1
  // still elaborates; the load value is then zero and nothing is tracked.
  localparam int SB_W = (WB_LAT > 1) ? $clog2(WB_LAT) : 1;
  // Branch counter must be able to hold BR_LAT itself.
  localparam int BC_W = (BR_LAT > 0) ? $clog2(BR_LAT + 1) : 1;

  localparam logic [SB_W-1:0]  SB_LOAD  = SB_W'(WB_LAT - 1);
  localparam logic [SB_W-1:0]  SB_ONE   = SB_W'(1);
  localparam logic [SB_W-1:0]  SB_ZERO  = SB_W'(0);
  localparam logic [BC_W-1:0]  BR_LOAD  = BC_W'(BR_LAT);
  localparam logic [BC_W-1:0]  BR_ONE   = BC_W'(1);
  localparam logic [BC_W-1:0]  BR_ZERO  = BC_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_BR_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [BC_W-1:0]         br_cnt_q, br_cnt_d;
  logic [31:0][SB_W-1:0]   sb_q, sb_d;
  logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;

  // ---------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------
  logic rs_pend_s;
  logic rt_pend_s;
  logic raw_hz_s;
  logic issue_s;
  logic pc_hold_s;
  logic ifid_hold_s;
  logic ifid_flush_s;
  logic idex_bubble_s;
  logic redirect_s;
  logic br_busy_s;
  logic stall_inc_s;
  logic sb_load_s;

  // RAW hazard detect: a used source register still has a write in flight.
  always_comb begin
    rs_pend_s = id_use_rs_i & (sb_q[id_rs_i] != SB_ZERO);
    rt_pend_s = id_use_rt_i & (sb_q[id_rt_i] != SB_ZERO);
    raw_hz_s  = id_valid_i & (rs_pend_s | rt_pend_s);
  end

  // FSM next-state and pipeline-control outputs; reset overrides everything.
  always_comb begin
    state_d       = state_q;
    br_cnt_d      = br_cnt_q;
    issue_s       = 1'b0;
    pc_hold_s     = 1'b0;
    ifid_hold_s   = 1'b0;
    ifid_flush_s  = 1'b0;
    idex_bubble_s = 1'b0;
    redirect_s    = 1'b0;
    br_busy_s     = 1'b0;
    stall_inc_s   = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (!id_valid_i) begin
          // Bubble in ID: pass a NOP down, let fetch run.
          idex_bubble_s = 1'b1;
        end else if (raw_hz_s) begin
          // Freeze PC and IF/ID, inject a bubble into EX.
          pc_hold_s     = 1'b1;
          ifid_hold_s   = 1'b1;
          idex_bubble_s = 1'b1;
          stall_inc_s   = 1'b1;
        end else begin
          issue_s = 1'b1;
          if (id_ctrl_i) begin
            // The fetched fall-through is speculative: squash it and keep
            // the PC until the datapath resolves the target.
            pc_hold_s    = 1'b1;
            ifid_flush_s = 1'b1;
            br_cnt_d     = BR_LOAD;
            state_d      = ST_BR_WAIT;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_BR_WAIT: begin
        idex_bubble_s = 1'b1;
        ifid_flush_s  = 1'b1;
        br_busy_s     = 1'b1;
        stall_inc_s   = 1'b1;
        br_cnt_d      = (br_cnt_q != BR_ZERO) ? (br_cnt_q - BR_ONE) : BR_ZERO;
        if (br_cnt_q == BR_ONE) begin
          // Next-PC is resolved now: load it and resume.
          redirect_s = 1'b1;
          state_d    = ST_RUN;
        end else begin
          pc_hold_s = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding: recover to RUN with a safe bubble.
        idex_bubble_s = 1'b1;
        pc_hold_s     = 1'b1;
        br_cnt_d      = BR_ZERO;
        state_d       = ST_RUN;
      end
    endcase

    if (rst) begin
      issue_s       = 1'b0;
      pc_hold_s     = 1'b1;
      ifid_hold_s   = 1'b0;
      ifid_flush_s  = 1'b1;
      idex_bubble_s = 1'b1;
      redirect_s    = 1'b0;
      br_busy_s     = 1'b0;
      stall_inc_s   = 1'b0;
      state_d       = ST_RUN;
      br_cnt_d      = BR_ZERO;
    end else begin
      state_d = state_d;
    end
  end

  // Scoreboard next value: fresh issue load beats the per-cycle decrement.
  always_comb begin
    sb_load_s = issue_s & id_we_i & (id_wd_i != 5'd0);
    sb_d      = sb_q;
    sb_d[0]   = SB_ZERO;
    for (int r = 1; r < 32; r++) begin
      if (sb_load_s && (id_wd_i == 5'(r))) begin
        sb_d[r] = SB_LOAD;
      end else if (sb_q[r] != SB_ZERO) begin
        sb_d[r] = sb_q[r] - SB_ONE;
      end else begin
        sb_d[r] = SB_ZERO;
      end
    end
  end

  // Saturating stall-cycle counter next value.
  always_comb begin
    if (stall_inc_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      br_cnt_q    <= BR_ZERO;
      sb_q        <= '0;
      stall_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      br_cnt_q    <= br_cnt_d;
      sb_q        <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign issue_o       = issue_s;
  assign pc_hold_o     = pc_hold_s;
  assign ifid_hold_o   = ifid_hold_s;
  assign ifid_flush_o  = ifid_flush_s;
  assign idex_bubble_o = idex_bubble_s;
  assign redirect_o    = redirect_s;
  assign br_busy_o     = br_busy_s;
  assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_mips_hazard_ctrl.sv
// Scoreboard bench for mips_hazard_ctrl. The driver applies one instruction
// per cycle, predicts the control outputs from a timeline model (cycle at
// which each register becomes readable, cycle at which a branch resolves)
// and queues the prediction; a monitor pops and compares every cycle.
// The counter width is shrunk so saturation is reachable.

module tb_mips_hazard_ctrl;

  localparam int WB_LAT   = 3;
  localparam int BR_LAT   = 3;
  localparam int TB_CNT_W = 6;
  localparam int CNT_SAT  = (1 << TB_CNT_W) - 1;

  logic                clk;
  logic                rst;
  logic                id_valid_i;
  logic [4:0]          id_rs_i;
  logic [4:0]          id_rt_i;
  logic                id_use_rs_i;
  logic                id_use_rt_i;
  logic                id_we_i;
  logic [4:0]          id_wd_i;
  logic                id_ctrl_i;
  logic                issue_o;
  logic                pc_hold_o;
  logic                ifid_hold_o;
  logic                ifid_flush_o;
  logic                idex_bubble_o;
  logic                redirect_o;
  logic                br_busy_o;
  logic [TB_CNT_W-1:0] stall_cnt_o;

  mips_hazard_ctrl #(
    .WB_LAT(WB_LAT),
    .BR_LAT(BR_LAT),
    .CNT_W (TB_CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_use_rs_i  (id_use_rs_i),
    .id_use_rt_i  (id_use_rt_i),
    .id_we_i      (id_we_i),
    .id_wd_i      (id_wd_i),
    .id_ctrl_i    (id_ctrl_i),
    .issue_o      (issue_o),
    .pc_hold_o    (pc_hold_o),
    .ifid_hold_o  (ifid_hold_o),
    .ifid_flush_o (ifid_flush_o),
    .idex_bubble_o(idex_bubble_o),
    .redirect_o   (redirect_o),
    .br_busy_o    (br_busy_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vector order:
  // {issue, pc_hold, ifid_hold, ifid_flush, idex_bubble, redirect, br_busy}
  typedef struct {
    logic [6:0] ctl;
    int         cnt;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference timeline model.
  int ready_at [32];  // first cycle at which register r may be read
  int br_end;         // cycle of the redirect for the branch in flight
  int m_cnt;
  int cyc;

  task automatic model_clear();
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    br_end = -1;
    m_cnt  = 0;
  endtask

  function automatic bit pending(input logic [4:0] r, input int c);
    return (r != 5'd0) && (c < ready_at[r]);
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic we,
                      input logic [4:0] wd, input logic ctrl, input logic r);
    exp_t e;
    bit   raw;
    bit   last;
    @(negedge clk);
    rst         = r;
    id_valid_i  = v;
    id_rs_i     = rs;
    id_rt_i     = rt;
    id_use_rs_i = urs;
    id_use_rt_i = urt;
    id_we_i     = we;
    id_wd_i     = wd;
    id_ctrl_i   = ctrl;
    #1;
    e.cyc = cyc;
    e.cnt = m_cnt;
    if (r) begin
      e.ctl = 7'b0101100;
      model_clear();
    end else if (cyc <= br_end) begin
      last  = (cyc == br_end);
      e.ctl = {1'b0, !last, 1'b0, 1'b1, 1'b1, last, 1'b1};
      if (m_cnt < CNT_SAT) m_cnt++;
    end else begin
      raw = v && ((urs && pending(rs, cyc)) || (urt && pending(rt, cyc)));
      if (!v) begin
        e.ctl = 7'b0000100;
      end else if (raw) begin
        e.ctl = 7'b0110100;
        if (m_cnt < CNT_SAT) m_cnt++;
      end else begin
        e.ctl = {1'b1, ctrl, 1'b0, ctrl, 1'b0, 1'b0, 1'b0};
        if (we && wd != 5'd0) ready_at[wd] = cyc + WB_LAT;
        if (ctrl) br_end = cyc + BR_LAT;
      end
    end
    exp_q.push_back(e);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Monitor: compare DUT outputs with the queued prediction each cycle.
  initial begin
    exp_t       e;
    logic [6:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {issue_o, pc_hold_o, ifid_hold_o, ifid_flush_o,
               idex_bubble_o, redirect_o, br_busy_o};
        checks++;
        if (got !== e.ctl) begin
          errors++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b (issue,pc_hold,ifid_hold,flush,bubble,redirect,busy)",
                   e.cyc, got, e.ctl);
        end
        checks++;
        if (stall_cnt_o !== TB_CNT_W'(e.cnt)) begin
          errors++;
          $display("FAIL stall_cnt cyc=%0d got=%0d exp=%0d", e.cyc, stall_cnt_o, e.cnt);
        end
        checks++;
        if ((ifid_hold_o & ifid_flush_o) !== 1'b0) begin
          errors++;
          $display("FAIL hold_flush_excl cyc=%0d got=%b exp=0", e.cyc, ifid_hold_o & ifid_flush_o);
        end
      end
    end
  end

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    rst = 1'b1; id_valid_i = 1'b0; id_rs_i = 5'd0; id_rt_i = 5'd0;
    id_use_rs_i = 1'b0; id_use_rt_i = 1'b0; id_we_i = 1'b0; id_wd_i = 5'd0;
    id_ctrl_i = 1'b0;
    cyc = 0;
    model_clear();

    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);

    // LWI r2, then BNEG reading r2: two stalls, issue, branch wait.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    repeat (3) step(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle(3);

    // Independent ADDIs.
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0);
    step(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);

    // J then fetch resumes.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);

    // r0 is never tracked; unused source does not stall.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    step(1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(3);

    // Back-to-back writes to r3, reader via rt waits for the second.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
    repeat (4) step(1'b1, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset during branch wait with r5 pending.
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0);
    step(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic over a small register window to provoke hazards.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 8) != 0,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           1'($urandom % 2), 1'($urandom % 2), 1'($urandom % 2),
           5'($urandom_range(0, 7)),
           ($urandom % 10) == 0,
           ($urandom % 120) == 0);
    end
    idle(2);

    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
